serial_pattern_tx: RTL and testbench

Parallel-load, LSB-first serializer that drives the 1-bit serial input of the team's pair-detect Mealy receiver (the detector flags two consecutive equal bits).
- Accepts a word through a valid/ready load handshake.
- Emits one bit per `step` strobe, then pulses `done`.
- Sits upstream of the detector in lab benches and in the top-level link. Replaces ad-hoc testbench bit loops.

---
 rtl/serial_pattern_tx_pkg.sv | 21 ++
 rtl/serial_pattern_tx_pair_expect.sv | 40 ++++
 rtl/serial_pattern_tx.sv | 110 +++++++++++
 tb/tb_serial_pattern_tx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pattern_tx_pkg.sv
// Shared types and helpers for the serial_pattern_tx serializer and its
// optional pair-detect expectation tracker.
package serial_pattern_tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    LAST1 = 2'd1,
    LAST0 = 2'd2
  } exp_state_t;

  // A zero or oversize length selects a full-width word.
  function automatic int unsigned norm_len(input int unsigned len, input int unsigned width);
    return ((len == 0) || (len > width)) ? width : len;
  endfunction

endpackage

// File: rtl/serial_pattern_tx_pair_expect.sv
// pair_expect_model: predicts the pair-detect receiver's registered flag for
// the bit currently on the serial line (used with SERIAL_PATTERN_TX_EXPECT_EN).
module pair_expect_model
  import serial_pattern_tx_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_advance,
  input  logic i_bit,
  input  logic i_valid,
  output logic o_exp
);

  exp_state_t r_state;
  exp_state_t w_next_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= NONE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (i_clear) begin
      w_next_state = NONE;
    end else if (i_advance) begin
      case (r_state)
        NONE:    w_next_state = i_bit ? LAST1 : LAST0;
        LAST1:   w_next_state = i_bit ? NONE  : LAST0;
        LAST0:   w_next_state = i_bit ? LAST1 : NONE;
        default: w_next_state = NONE;
      endcase
    end
  end

  // A pair completes when the bit on the line repeats the remembered one.
  assign o_exp = i_valid && (((r_state == LAST1) && i_bit) || ((r_state == LAST0) && !i_bit));

endmodule

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: valid/ready-loaded, LSB-first, step-strobed serializer.
// Define SERIAL_PATTERN_TX_EXPECT_EN to add the exp_out pair-detect prediction.
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CNT_W-1:0] load_len,
  input  logic             step,
  input  logic             abort,
  output logic             out_bit,
  output logic             out_valid,
  output logic             busy,
  output logic             done
`ifdef SERIAL_PATTERN_TX_EXPECT_EN
  ,
  output logic             exp_out
`endif
);

  tx_state_t        r_state;
  tx_state_t        w_next_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_len;
  logic             r_done;

  logic w_shift;
  logic w_fire;
  logic w_last;

  assign w_shift = (r_state == SHIFT);
  assign w_fire  = (r_state == IDLE) && load_valid;
  assign w_last  = (r_cnt == (r_len - CNT_W'(1)));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: the next-state default is assigned first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (load_valid) w_next_state = SHIFT;
      SHIFT:   if (abort || (step && w_last)) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: the length register is reset along with the datapath; it is a
  // single register, not a memory, so resetting it costs nothing meaningful.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_fire) begin
        r_shreg <= load_data;
        r_cnt   <= '0;
        r_len   <= CNT_W'(norm_len(32'(load_len), WIDTH));
      end else if (w_shift) begin
        // abort outranks step: the bit is not counted and done stays low.
        if (abort) begin
          r_shreg <= '0;
          r_cnt   <= '0;
        end else if (step) begin
          r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
          if (w_last) begin
            r_cnt  <= '0;
            r_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

  assign load_ready = (r_state == IDLE);
  assign busy       = w_shift;
  assign out_valid  = w_shift;
  assign out_bit    = w_shift && r_shreg[0];
  assign done       = r_done;

`ifdef SERIAL_PATTERN_TX_EXPECT_EN
  pair_expect_model u_expect (
    .clk       (clock),
    .rst_n     (reset),
    .i_clear   (w_fire || (w_shift && abort)),
    .i_advance (w_shift && step && !abort),
    .i_bit     (r_shreg[0]),
    .i_valid   (w_shift),
    .o_exp     (exp_out)
  );
`endif

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed self-checking bench for serial_pattern_tx; exp_out checks are
// compiled in when SERIAL_PATTERN_TX_EXPECT_EN is defined.
module tb_serial_pattern_tx;

  localparam int WIDTH = 16;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [CNT_W-1:0] load_len;
  logic             step;
  logic             abort;
  logic             out_bit;
  logic             out_valid;
  logic             busy;
  logic             done;
`ifdef SERIAL_PATTERN_TX_EXPECT_EN
  logic             exp_out;
`endif

  int n_checks = 0;
  int n_errors = 0;

  serial_pattern_tx #(.WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_len   (load_len),
    .step       (step),
    .abort      (abort),
    .out_bit    (out_bit),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done)
`ifdef SERIAL_PATTERN_TX_EXPECT_EN
    ,
    .exp_out    (exp_out)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic observed, input logic expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic check_exp(input string tag, input logic expected);
`ifdef SERIAL_PATTERN_TX_EXPECT_EN
    check(tag, exp_out, expected);
`else
    if (expected === 1'bx) $display("unused %s", tag);
`endif
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] data, input logic [CNT_W-1:0] len);
    load_valid = 1'b1;
    load_data  = data;
    load_len   = len;
    cyc();
    load_valid = 1'b0;
  endtask

  logic [15:0] word_a = 16'b0101011101110010;
  logic [15:0] exp_a  = 16'h0228;
  logic [3:0]  word_c = 4'b0110;

  initial begin
    reset = 1'b0; load_valid = 1'b0; load_data = '0; load_len = '0;
    step = 1'b0; abort = 1'b0;

    // Reset state
    cyc();
    check("rst_load_ready", load_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_bit", out_bit, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    reset = 1'b1;
    cyc();

    // Full 16-bit word (len=0), step every cycle
    do_load(word_a, 5'd0);
    step = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t1_bit%0d", i), out_bit, word_a[i]);
      check($sformatf("t1_valid%0d", i), out_valid, 1'b1);
      check($sformatf("t1_ready%0d", i), load_ready, 1'b0);
      check($sformatf("t1_nodone%0d", i), done, 1'b0);
      check_exp($sformatf("t1_exp%0d", i), exp_a[i]);
      cyc();
    end
    step = 1'b0;
    check("t1_done", done, 1'b1);
    check("t1_done_ready", load_ready, 1'b1);
    check("t1_done_valid", out_valid, 1'b0);
    cyc();
    check("t1_done_clear", done, 1'b0);

    // 16'hFFFF, len=3, step every other cycle
    do_load(16'hFFFF, 5'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_bit%0d", i), out_bit, 1'b1);
      check_exp($sformatf("t2_exp%0d", i), (i == 1));
      step = 1'b0;
      cyc();
      check($sformatf("t2_stall%0d", i), out_bit, 1'b1);
      check($sformatf("t2_busy%0d", i), busy, 1'b1);
      check($sformatf("t2_nodone%0d", i), done, 1'b0);
      step = 1'b1;
      cyc();
    end
    step = 1'b0;
    check("t2_done", done, 1'b1);
    check("t2_done_ready", load_ready, 1'b1);
    cyc();
    check("t2_done_clear", done, 1'b0);

    // 16'h00A5, abort on the 4th step
    do_load(16'h00A5, 5'd0);
    step = 1'b1;
    check("t3_bit0", out_bit, 1'b1); cyc();
    check("t3_bit1", out_bit, 1'b0); cyc();
    check("t3_bit2", out_bit, 1'b1); cyc();
    check("t3_bit3", out_bit, 1'b0);
    abort = 1'b1;
    cyc();
    step = 1'b0;
    check("t3_abort_done", done, 1'b0);
    check("t3_abort_ready", load_ready, 1'b1);
    check("t3_abort_valid", out_valid, 1'b0);
    check("t3_abort_busy", busy, 1'b0);
    // abort still high in IDLE: the load must go through
    do_load(16'h0003, 5'd2);
    abort = 1'b0;
    check("t3_prev_done", done, 1'b0);
    check("t3b_valid", out_valid, 1'b1);
    check("t3b_bit0", out_bit, 1'b1);
    check_exp("t3b_exp0", 1'b0);
    step = 1'b1;
    cyc();
    check("t3b_bit1", out_bit, 1'b1);
    check_exp("t3b_exp1", 1'b1);
    cyc();
    step = 1'b0;
    check("t3b_done", done, 1'b1);
    cyc();

    // load_valid during SHIFT is ignored
    do_load({12'h000, word_c}, 5'd4);
    load_valid = 1'b1;
    load_data  = 16'h1234;
    load_len   = 5'd0;
    step = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_ready%0d", i), load_ready, 1'b0);
      check($sformatf("t4_bit%0d", i), out_bit, word_c[i]);
      cyc();
    end
    load_valid = 1'b0;
    step = 1'b0;
    check("t4_done", done, 1'b1);
    check("t4_idle", out_valid, 1'b0);
    cyc();
    check("t4_not_loaded", out_valid, 1'b0);

    // Async reset while the 7th bit is on the line
    do_load(word_a, 5'd0);
    step = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    check("t5_bit6", out_bit, word_a[6]);
    #2;
    reset = 1'b0;
    #1;
    step = 1'b0;
    check("t5_rst_valid", out_valid, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_ready", load_ready, 1'b1);
    check("t5_rst_done", done, 1'b0);
    cyc();
    check("t5_rst_done_hold", done, 1'b0);
    reset = 1'b1;
    cyc();
    check("t5_post_done", done, 1'b0);
    check("t5_post_valid", out_valid, 1'b0);

    // Back-to-back 2'b01 then 2'b10, len=2, step held high
    load_valid = 1'b1;
    load_data  = 16'h0001;
    load_len   = 5'd2;
    step = 1'b1;
    cyc();
    load_data = 16'h0002;
    check("t6_a_bit0", out_bit, 1'b1);
    check("t6_a_done0", done, 1'b0);
    cyc();
    check("t6_a_bit1", out_bit, 1'b0);
    cyc();
    check("t6_gap_done", done, 1'b1);
    check("t6_gap_valid", out_valid, 1'b0);
    check("t6_gap_ready", load_ready, 1'b1);
    cyc();
    load_valid = 1'b0;
    check("t6_b_bit0", out_bit, 1'b0);
    check("t6_b_done0", done, 1'b0);
    cyc();
    check("t6_b_bit1", out_bit, 1'b1);
    check("t6_b_done1", done, 1'b0);
    cyc();
    step = 1'b0;
    check("t6_b_done", done, 1'b1);
    cyc();
    check("t6_b_done_clear", done, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
